// File: rtl/apb_accum_pkg.sv
// Shared types and register-map constants for the multi-channel APB accumulator.
package apb_accum_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_e;

  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_CTRL   = 4'h4;
  localparam logic [3:0] OFS_RESULT = 4'h8;
  localparam logic [3:0] OFS_STATUS = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_OP_LSB = 2;
  localparam int CTRL_SAT    = 4;
  localparam int CTRL_IE     = 5;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF  = 2;

endpackage

// File: rtl/apb_accum_channel.sv
// One accumulator channel: DATA/CTRL/RESULT/STATUS registers, latency down-counter and ALU.
// Write strobes arrive already qualified; START/CLR while busy are filtered upstream.
module apb_accum_channel
  import apb_accum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_data,
  input  logic              wr_ctrl,
  input  logic              wr_status,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] ctrl,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] status,
  output logic              busy,
  output logic              irq_req
);

  localparam int CNT_W = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OP_LAT - 1);

  logic [DATA_W-1:0] data_q, result_q, operand_q, alu_res;
  logic [DATA_W:0]   sum;
  logic [CNT_W-1:0]  cnt_q;
  op_e               op_q, run_op_q;
  logic              sat_q, ie_q, run_sat_q, busy_q, done_q, ovf_q, alu_carry;

  always_comb begin
    sum       = {1'b0, result_q} + {1'b0, operand_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (run_op_q)
      OP_OR:  alu_res = result_q | operand_q;
      OP_AND: alu_res = result_q & operand_q;
      OP_XOR: alu_res = result_q ^ operand_q;
      OP_ADD: begin
        alu_carry = sum[DATA_W];
        alu_res   = (sum[DATA_W] && run_sat_q) ? '1 : sum[DATA_W-1:0];
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      result_q  <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
      op_q      <= OP_OR;
      run_op_q  <= OP_OR;
      sat_q     <= 1'b0;
      ie_q      <= 1'b0;
      run_sat_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (wr_data) data_q <= wdata;
      if (wr_ctrl) begin
        op_q  <= op_e'(wdata[CTRL_OP_LSB +: 2]);
        sat_q <= wdata[CTRL_SAT];
        ie_q  <= wdata[CTRL_IE];
        if (wdata[CTRL_CLR]) result_q <= '0;
        // The running op uses the fields of the START write itself, not later CTRL contents.
        if (wdata[CTRL_START]) begin
          operand_q <= data_q;
          run_op_q  <= op_e'(wdata[CTRL_OP_LSB +: 2]);
          run_sat_q <= wdata[CTRL_SAT];
          busy_q    <= 1'b1;
          cnt_q     <= CNT_LOAD;
        end
      end
      if (wr_status) begin
        if (wdata[ST_DONE]) done_q <= 1'b0;
        if (wdata[ST_OVF])  ovf_q  <= 1'b0;
      end
      // Completion comes after the W1C so a same-cycle set wins.
      if (busy_q) begin
        if (cnt_q == '0) begin
          result_q <= alu_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          if (alu_carry) ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl                      = '0;
    ctrl[CTRL_OP_LSB +: 2]    = op_q;
    ctrl[CTRL_SAT]            = sat_q;
    ctrl[CTRL_IE]             = ie_q;
    status                    = '0;
    status[ST_BUSY]           = busy_q;
    status[ST_DONE]           = done_q;
    status[ST_OVF]            = ovf_q;
  end

  assign data    = data_q;
  assign result  = result_q;
  assign busy    = busy_q;
  assign irq_req = done_q & ie_q;

endmodule

// File: rtl/apb_accum_array.sv
// APB3 slave with NUM_CH accumulator channels: address decode, bus FSM, read mux, irq.
// state | meaning
// IDLE  | waiting for PSEL&PENABLE; response and write commit taken on exit
// ACK   | PREADY=1 for one cycle, then back to IDLE unconditionally
module apb_accum_array
  import apb_accum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8,
  parameter int OP_LAT = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              irq
);

  localparam int CH_W = ADDR_W - 4;
  localparam logic [CH_W:0] NUM_CH_W = (CH_W+1)'(NUM_CH);

  bus_state_e        state_q;
  logic [CH_W-1:0]   ch_idx;
  logic [3:0]        ofs;
  logic              access, ch_ok, sel_busy, err, commit;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] ch_ctrl [NUM_CH];
  logic [DATA_W-1:0] ch_res  [NUM_CH];
  logic [DATA_W-1:0] ch_stat [NUM_CH];
  logic [NUM_CH-1:0] ch_busy, ch_irq;

  assign ch_idx = PADDR[ADDR_W-1:4];
  assign ofs    = PADDR[3:0];
  assign ch_ok  = {1'b0, ch_idx} < NUM_CH_W;
  assign access = (state_q == IDLE) && PSEL && PENABLE;

  always_comb begin
    sel_busy = 1'b0;
    rd_mux   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_ok && ch_idx == CH_W'(i)) begin
        sel_busy = ch_busy[i];
        case (ofs)
          OFS_DATA:   rd_mux = ch_data[i];
          OFS_CTRL:   rd_mux = ch_ctrl[i];
          OFS_RESULT: rd_mux = ch_res[i];
          OFS_STATUS: rd_mux = ch_stat[i];
          default:    rd_mux = '0;
        endcase
      end
    end
  end

  assign err = (ofs[1:0] != 2'b00) || !ch_ok
            || (PWRITE && ofs == OFS_RESULT)
            || (PWRITE && ofs == OFS_CTRL && sel_busy
                && (PWDATA[CTRL_START] || PWDATA[CTRL_CLR]));
  assign commit = access && PWRITE && !err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic hit;
    assign hit = commit && (ch_idx == CH_W'(g));
    apb_accum_channel #(
      .DATA_W(DATA_W),
      .OP_LAT(OP_LAT)
    ) u_ch (
      .clk      (PCLK),
      .rst      (PRESET),
      .wr_data  (hit && ofs == OFS_DATA),
      .wr_ctrl  (hit && ofs == OFS_CTRL),
      .wr_status(hit && ofs == OFS_STATUS),
      .wdata    (PWDATA),
      .data     (ch_data[g]),
      .ctrl     (ch_ctrl[g]),
      .result   (ch_res[g]),
      .status   (ch_stat[g]),
      .busy     (ch_busy[g]),
      .irq_req  (ch_irq[g])
    );
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            state_q <= ACK;
            PREADY  <= 1'b1;
            PSLVERR <= err;
            PRDATA  <= (PWRITE || err) ? '0 : rd_mux;
          end
        end
        ACK: begin
          state_q <= IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq = |ch_irq;

endmodule

// File: tb/tb_apb_accum_array.sv
// Directed bench for apb_accum_array: stimulus pushes expected responses, a monitor pops and compares.
module tb_apb_accum_array;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 8;
  localparam int OP_LAT = 4;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE = 1'b0;
  logic [ADDR_W-1:0] PADDR = '0;
  logic [DATA_W-1:0] PWDATA = '0;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY, PSLVERR, irq;

  apb_accum_array #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .OP_LAT(OP_LAT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (!PRESET && PREADY === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pready: got PREADY=1 expected no transfer pending");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, PRDATA, e.rdata);
        check({e.name, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, e.err});
      end
    end
  end

  // Called just after a rising edge; returns just after the rising edge that ends the transfer.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input string name);
    exp_t e;
    int   waits;
    logic got;
    e.name = name; e.rdata = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) got = 1'b1;
      else waits++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no PREADY in 8 cycles expected PREADY", name);
      e = sb_q.pop_back();
    end else begin
      check({name, "_waits"}, waits, 1);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wd, input logic exp_err, input string name);
    apb(1'b1, addr, wd, 32'h0, exp_err, name);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input logic exp_err, input string name);
    apb(1'b0, addr, 32'h0, exp, exp_err, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic got;

    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", {31'b0, PREADY}, 0);
    check("rst_prdata", PRDATA, 0);
    check("rst_pslverr", {31'b0, PSLVERR}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    PRESET = 1'b0;

    // 1: every register of every channel reads zero after reset
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int o = 0; o < 4; o++)
        rd(8'(ch * 16 + o * 4), 32'h0, 1'b0, $sformatf("t1_ch%0d_ofs%0h", ch, o * 4));

    // 2: OR start on ch1, observe BUSY then DONE
    wr(8'h10, 32'h0000_00F0, 1'b0, "t2_data");
    wr(8'h14, 32'h0000_0001, 1'b0, "t2_start");
    rd(8'h1C, 32'h1, 1'b0, "t2_status_busy");
    rd(8'h1C, 32'h2, 1'b0, "t2_status_done");
    rd(8'h18, 32'h0000_00F0, 1'b0, "t2_result");
    rd(8'h14, 32'h0, 1'b0, "t2_ctrl");

    // 3: ADD wrap with overflow, then saturating ADD after CLR+START
    wr(8'h20, 32'hFFFF_FFF0, 1'b0, "t3_data");
    wr(8'h24, 32'h0000_000D, 1'b0, "t3_add1");
    rd(8'h2C, 32'h1, 1'b0, "t3_st1");
    wr(8'h24, 32'h0000_000D, 1'b0, "t3_add2");
    rd(8'h2C, 32'h3, 1'b0, "t3_st2");
    rd(8'h2C, 32'h6, 1'b0, "t3_st3");
    rd(8'h28, 32'hFFFF_FFE0, 1'b0, "t3_wrap");
    wr(8'h2C, 32'h6, 1'b0, "t3_w1c");
    wr(8'h24, 32'h0000_001F, 1'b0, "t3_clr_add_sat");
    rd(8'h2C, 32'h1, 1'b0, "t3_st4");
    wr(8'h24, 32'h0000_001D, 1'b0, "t3_add_sat");
    rd(8'h2C, 32'h3, 1'b0, "t3_st5");
    rd(8'h2C, 32'h6, 1'b0, "t3_st6");
    rd(8'h28, 32'hFFFF_FFFF, 1'b0, "t3_sat");
    rd(8'h24, 32'h0000_001C, 1'b0, "t3_ctrl");

    // 4: second START while busy is rejected, XOR applied once
    wr(8'h00, 32'h5, 1'b0, "t4_data");
    wr(8'h04, 32'h9, 1'b0, "t4_start");
    wr(8'h04, 32'h25, 1'b1, "t4_start_busy");
    rd(8'h0C, 32'h2, 1'b0, "t4_status");
    rd(8'h08, 32'h5, 1'b0, "t4_result");
    rd(8'h04, 32'h8, 1'b0, "t4_ctrl");

    // 5: error accesses leave state alone
    wr(8'h08, 32'h1234, 1'b1, "t5_wr_result");
    rd(8'h40, 32'h0, 1'b1, "t5_rd_badch");
    rd(8'h02, 32'h0, 1'b1, "t5_rd_misalign");
    wr(8'h02, 32'hABCD, 1'b1, "t5_wr_misalign");
    rd(8'h08, 32'h5, 1'b0, "t5_result_kept");
    rd(8'h00, 32'h5, 1'b0, "t5_data_kept");

    // 6: interrupt, W1C, reset mid-op
    wr(8'h30, 32'h3, 1'b0, "t6_data");
    wr(8'h34, 32'h21, 1'b0, "t6_start_ie");
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge PCLK);
      n++;
      if (irq === 1'b1) got = 1'b1;
    end
    check("t6_irq_latency", n, OP_LAT);
    check("t6_irq_set", {31'b0, irq}, 1);
    @(posedge PCLK); #1;
    rd(8'h3C, 32'h2, 1'b0, "t6_status_done");
    wr(8'h3C, 32'h2, 1'b0, "t6_w1c");
    check("t6_irq_clr", {31'b0, irq}, 0);
    rd(8'h38, 32'h3, 1'b0, "t6_result");
    wr(8'h30, 32'hC, 1'b0, "t6_data2");
    wr(8'h34, 32'h21, 1'b0, "t6_start2");
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    repeat (6) @(posedge PCLK);
    #1;
    check("t6_irq_after_rst", {31'b0, irq}, 0);
    rd(8'h3C, 32'h0, 1'b0, "t6_status_rst");
    rd(8'h38, 32'h0, 1'b0, "t6_result_rst");
    rd(8'h34, 32'h0, 1'b0, "t6_ctrl_rst");

    // reset during the access phase: no PREADY on the following cycle
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("t6_pready_rst", {31'b0, PREADY}, 0);
    PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
    @(posedge PCLK); #1;
    rd(8'h00, 32'h0, 1'b0, "t6_data_rst");

    repeat (4) @(posedge PCLK);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
